// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// Frame controller for the UART transmit path. It sits directly downstream of
// the Serializer: it gates the Serializer shift enable, watches its last-bit
// flag and builds the line frame
//   start(0) | DATA_WIDTH data bits, LSB first | optional parity | stop(1)
// at one line bit per clk.
//
// Optional build feature:
//   UART_TX_TWO_STOP_EN  - when defined, a second stop bit (STOP2) is appended.
//
// Parameters:
//   DATA_WIDTH   data bits per frame; must match the Serializer width.
//
// Ports:
//   clk          system clock, one TX bit per cycle
//   rst          synchronous, active-high reset
//   P_Data       parallel byte, sampled on an accepted Data_valid (parity source)
//   Data_valid   frame request, accepted only while busy=0
//   PAR_EN       1 = insert parity bit (sampled at acceptance)
//   PAR_TYP      0 = even, 1 = odd parity (sampled at acceptance)
//   ser_data     current data bit from the Serializer
//   ser_done     Serializer last-bit flag
//   ser_en       shift enable to the Serializer
//   TX_OUT       serial line, idle high
//   busy         frame in progress
//   frame_err    one-clk pulse when ser_done fails to arrive in time
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_TWO_STOP_EN
        , S_STOP2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_par_bit;
    logic             r_par_en;
    logic             r_frame_err;
    logic             w_accept;
    logic             w_timeout;

    assign w_accept  = (r_state == S_IDLE) && Data_valid;
    // Last nominal DATA cycle reached without the Serializer flagging its last
    // bit: abandon the data phase and close the frame with a stop bit.
    assign w_timeout = (r_state == S_DATA) && !ser_done && (r_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and line decode. TX_OUT is left combinational so each data
    // bit lines up with the Serializer shift it belongs to.
    always_comb begin
        w_next = r_state;
        ser_en = 1'b0;
        TX_OUT = 1'b1;
        busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (Data_valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                TX_OUT = 1'b0;
                w_next = S_DATA;
            end
            S_DATA: begin
                ser_en = 1'b1;
                TX_OUT = ser_data;
                if (ser_done) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end else if (w_timeout) begin
                    w_next = S_STOP;
                end
            end
            S_PARITY: begin
                TX_OUT = r_par_bit;
                w_next = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                w_next = S_STOP2;
`else
                w_next = S_IDLE;
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            S_STOP2: begin
                w_next = S_IDLE;
            end
`endif
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: parity/config capture, DATA bit counter, error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit   <= 1'b0;
            r_par_en    <= 1'b0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_accept) begin
                // Parity type is folded into the stored bit, so only the
                // final line value needs to be kept for the frame.
                r_par_bit <= (^P_Data) ^ PAR_TYP;
                r_par_en  <= PAR_EN;
            end
            r_cnt       <= ((r_state == S_DATA) && (w_next == S_DATA)) ? r_cnt + 1'b1 : '0;
            r_frame_err <= w_timeout;
        end
    end

    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] P_Data;
    logic          Data_valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_data;
    logic          ser_done;
    logic          ser_en;
    logic          TX_OUT;
    logic          busy;
    logic          frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_Data     (P_Data),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Simple Serializer: loads on an accepted request, shifts LSB first on
    // ser_en, raises its last-bit flag while the final bit is presented.
    logic [DW-1:0] ser_sh;
    logic [3:0]    ser_cnt;
    logic          stub_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_sh  <= '0;
            ser_cnt <= '0;
        end else if (Data_valid && !busy) begin
            ser_sh  <= P_Data;
            ser_cnt <= '0;
        end else if (ser_en) begin
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt + 4'd1;
        end
    end

    assign ser_data = ser_sh[0];
    assign ser_done = !stub_done && (ser_cnt == 4'(DW - 1));

    typedef struct {
        logic [DW-1:0] data;
        logic          par_en;
        logic          par_typ;
        logic          stub;
        int            len;      // frame length with a single stop bit
        bit [0:11]     bits;     // expected TX_OUT per frame cycle, first bit leftmost
        int            err_idx;  // frame cycle carrying frame_err, -1 if none
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one frame, optionally pulsing Data_valid at frame cycle glitch_at,
    // and scrambles the config inputs mid-frame.
    task automatic run_frame(input vec_t v, input int glitch_at, input string tag);
        bit [0:15] act_bits, exp_bits, act_err, exp_err;
        int n, en_cnt, exp_len;
        act_bits = '0; exp_bits = '0; act_err = '0; exp_err = '0;
        n = 0; en_cnt = 0;
        exp_len = v.len + EXTRA;
        for (int i = 0; i < exp_len; i++) exp_bits[i] = (i < v.len) ? v.bits[i] : 1'b1;
        if (v.err_idx >= 0) exp_err[v.err_idx] = 1'b1;

        @(negedge clk);
        stub_done  = v.stub;
        P_Data     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!busy) break;
            act_bits[k] = TX_OUT;
            act_err[k]  = frame_err;
            if (ser_en) en_cnt++;
            n++;
            if (k == 2) begin
                P_Data  = ~v.data;
                PAR_EN  = ~v.par_en;
                PAR_TYP = ~v.par_typ;
            end
            if (k == glitch_at) begin
                Data_valid = 1'b1;
                P_Data     = 8'h00;
            end else begin
                Data_valid = 1'b0;
            end
            @(negedge clk);
        end
        Data_valid = 1'b0;
        chk({tag, " frame length"}, n, exp_len);
        chk({tag, " line bits"}, act_bits, exp_bits);
        chk({tag, " ser_en cycles"}, en_cnt, DW);
        chk({tag, " frame_err cycles"}, act_err, exp_err);
        stub_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_busy;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 12'b0101_0010_1010, -1};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 12'b0101_0010_1110, -1};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'b0101_0010_1100, -1};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 10, 12'b0001_1110_0100, -1};
        vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 11, 12'b0100_0000_0110, -1};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 11, 12'b0111_1111_1110, -1};
        vecs[6] = '{8'hA5, 1'b1, 1'b0, 1'b1, 10, 12'b0101_0010_1100,  9};

        rst = 1'b1; P_Data = '0; Data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        stub_done = 1'b0;

        // Reset held for two clocks, then released
        @(negedge clk);
        chk("reset c1 outputs", {TX_OUT, busy, ser_en, frame_err}, 4'b1000);
        @(negedge clk);
        chk("reset c2 outputs", {TX_OUT, busy, ser_en, frame_err}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset outputs", {TX_OUT, busy, ser_en, frame_err}, 4'b1000);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], -1, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Data_valid pulsed during DATA: frame unchanged, no second frame
        run_frame(vecs[0], 4, "glitch");
        idle_busy = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy) idle_busy++;
            @(negedge clk);
        end
        chk("glitch no second frame", idle_busy, 0);

        // rst asserted in DATA cycle 4
        @(negedge clk);
        P_Data = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst test in DATA", {busy, ser_en}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid-frame outputs", {TX_OUT, busy, ser_en, frame_err}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);
        chk("after mid-frame rst idle", {TX_OUT, busy, ser_en}, 3'b100);

        // A fresh frame still works after the abort
        run_frame(vecs[3], -1, "post-rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
